dmem_ctrl: RTL and testbench

//  Data-memory port controller directly downstream of load_fu. Takes single-cycle load
//  (start_load/Dmem_addr) and store requests, drives the proc2mem bus, tracks outstanding

---
 rtl/dmem_ctrl_if.sv | 38 +++
 rtl/dmem_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: proc2mem / mem2proc data-memory bus between dmem_ctrl and the
// system memory arbiter. The controller side uses the master modport.
interface dmem_ctrl_if #(
  parameter int TAG_W = 4
);

  logic [1:0]       proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [1:0]       proc2mem_size;
  logic             mem_gnt;
  logic [TAG_W-1:0] mem2proc_transaction_tag;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_data_tag;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    output proc2mem_size,
    input  mem_gnt,
    input  mem2proc_transaction_tag,
    input  mem2proc_data,
    input  mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    input  proc2mem_size,
    output mem_gnt,
    output mem2proc_transaction_tag,
    output mem2proc_data,
    output mem2proc_data_tag
  );

endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory port controller sitting behind load_fu.
// Issues loads/stores onto the proc2mem bus, holds a refused request in a
// one-entry retry buffer, tracks outstanding load tags and broadcasts returned
// blocks one cycle after the response.
// Optional build macro DMEM_CTRL_STATS_EN adds saturating stat_loads,
// stat_stores and stat_rejects counters as extra outputs.
module dmem_ctrl #(
  parameter int MAX_OUT = 4,
  parameter int TAG_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_load,
  input  logic [31:0] Dmem_addr,
  input  logic        start_store,
  input  logic [31:0] store_addr,
  input  logic [63:0] store_data,
  input  logic [1:0]  store_size,
  dmem_ctrl_if.master mem,
  output logic        dm_stalled,
  output logic        store_done,
  output logic        Dmem_data_ready,
  output logic [31:0] Dmem_base_addr,
  output logic [63:0] Dmem_load_data
`ifdef DMEM_CTRL_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_rejects
`endif
);

  localparam logic [1:0] MEM_NONE    = 2'd0;
  localparam logic [1:0] MEM_LOAD    = 2'd1;
  localparam logic [1:0] MEM_STORE   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  localparam int IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  // ST_RETRY means the retry buffer holds a refused request that must go out
  // before anything new is taken from upstream.
  typedef enum logic {
    ST_OPEN  = 1'b0,
    ST_RETRY = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Retry buffer contents (load addresses are stored already block-aligned)
  logic        rb_store_reg, rb_store_next;
  logic [31:0] rb_addr_reg,  rb_addr_next;
  logic [63:0] rb_data_reg,  rb_data_next;
  logic [1:0]  rb_size_reg,  rb_size_next;

  // Outstanding load table
  logic [MAX_OUT-1:0] ent_valid_reg;
  logic [TAG_W-1:0]   ent_tag_reg  [MAX_OUT];
  logic [31:0]        ent_addr_reg [MAX_OUT];

  // Selected request for this cycle
  logic        src_valid;
  logic        src_store;
  logic [31:0] src_addr;
  logic [63:0] src_data;
  logic [1:0]  src_size;
  logic        bus_drive;
  logic        accept;
  logic        load_accept;

  // Table lookup results
  logic [MAX_OUT-1:0] hit_vec;
  logic [MAX_OUT-1:0] alloc_sel;
  logic [MAX_OUT-1:0] free_sel;
  logic               hit_found;
  logic [IDX_W-1:0]   hit_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [CNT_W-1:0]   valid_count;
  logic               resp_tag_nz;

  // Low address bits of a load are dropped on purpose: the bus always
  // fetches the whole 8-byte block.
  logic unused_load_offset;
  assign unused_load_offset = ^Dmem_addr[2:0];

  // Pick the request for this cycle: retry buffer first, then store, then load.
  always_comb begin
    src_valid = 1'b0;
    src_store = 1'b0;
    src_addr  = '0;
    src_data  = '0;
    src_size  = '0;
    if (state_reg == ST_RETRY) begin
      src_valid = 1'b1;
      src_store = rb_store_reg;
      src_addr  = rb_addr_reg;
      src_data  = rb_data_reg;
      src_size  = rb_size_reg;
    end else if (start_store) begin
      src_valid = 1'b1;
      src_store = 1'b1;
      src_addr  = store_addr;
      src_data  = store_data;
      src_size  = store_size;
    end else if (start_load) begin
      src_valid = 1'b1;
      src_store = 1'b0;
      src_addr  = {Dmem_addr[31:3], 3'b000};
      src_data  = '0;
      src_size  = SIZE_DOUBLE;
    end
  end

  assign bus_drive   = ~reset & src_valid & mem.mem_gnt;
  assign accept      = bus_drive & (mem.mem2proc_transaction_tag != '0);
  assign load_accept = accept & ~src_store;
  assign store_done  = accept & src_store;

  // Drive the memory bus only when granted; otherwise park it at zero.
  always_comb begin
    mem.proc2mem_command = MEM_NONE;
    mem.proc2mem_addr    = '0;
    mem.proc2mem_data    = '0;
    mem.proc2mem_size    = '0;
    if (bus_drive) begin
      mem.proc2mem_command = src_store ? MEM_STORE : MEM_LOAD;
      mem.proc2mem_addr    = src_addr;
      mem.proc2mem_data    = src_data;
      mem.proc2mem_size    = src_size;
    end
  end

  assign resp_tag_nz = (mem.mem2proc_data_tag != '0);

  // Per-entry response match, allocation and release strobes.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUT; gi++) begin : g_ent
      assign hit_vec[gi]   = ent_valid_reg[gi] & resp_tag_nz &
                             (ent_tag_reg[gi] == mem.mem2proc_data_tag);
      assign alloc_sel[gi] = load_accept & free_found & (free_idx == IDX_W'(gi));
      assign free_sel[gi]  = hit_found & (hit_idx == IDX_W'(gi));
    end
  endgenerate

  // Lowest-index free slot and lowest-index matching slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!ent_valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (hit_vec[i]) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  // Number of loads currently waiting for data.
  always_comb begin
    valid_count = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      valid_count = valid_count + CNT_W'(ent_valid_reg[i]);
    end
  end

  // Stall comes from registered state only, so load_fu never sees a loop
  // through its own start strobes.
  assign dm_stalled = ~reset & ((state_reg == ST_RETRY) |
                                (valid_count == CNT_W'(MAX_OUT)));

  // Retry FSM: capture a refused new request, release it once accepted.
  always_comb begin
    state_next    = state_reg;
    rb_store_next = rb_store_reg;
    rb_addr_next  = rb_addr_reg;
    rb_data_next  = rb_data_reg;
    rb_size_next  = rb_size_reg;
    case (state_reg)
      ST_OPEN: begin
        if (src_valid && !accept) begin
          state_next    = ST_RETRY;
          rb_store_next = src_store;
          rb_addr_next  = src_addr;
          rb_data_next  = src_data;
          rb_size_next  = src_size;
        end
      end
      ST_RETRY: begin
        if (accept) begin
          state_next = ST_OPEN;
        end
      end
      default: state_next = ST_OPEN;
    endcase
  end

  // Retry FSM state and buffer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_OPEN;
      rb_store_reg <= 1'b0;
      rb_addr_reg  <= '0;
      rb_data_reg  <= '0;
      rb_size_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      rb_store_reg <= rb_store_next;
      rb_addr_reg  <= rb_addr_next;
      rb_data_reg  <= rb_data_next;
      rb_size_reg  <= rb_size_next;
    end
  end

  // Outstanding table: allocate on load accept, release on matching response.
  // A slot is never both allocated (must be free) and released (must be valid).
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid_reg <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (alloc_sel[i]) begin
          ent_valid_reg[i] <= 1'b1;
          ent_tag_reg[i]   <= mem.mem2proc_transaction_tag;
          ent_addr_reg[i]  <= src_addr;
        end else if (free_sel[i]) begin
          ent_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast of a returned load block (one-cycle ready pulse).
  always_ff @(posedge clock) begin
    if (reset) begin
      Dmem_data_ready <= 1'b0;
      Dmem_base_addr  <= '0;
      Dmem_load_data  <= '0;
    end else begin
      Dmem_data_ready <= hit_found;
      if (hit_found) begin
        Dmem_base_addr <= ent_addr_reg[hit_idx];
        Dmem_load_data <= mem.mem2proc_data;
      end
    end
  end

  // The stall must keep the table from ever being asked for a slot it lacks.
  assert property (@(posedge clock) disable iff (reset) !(load_accept && !free_found));

`ifdef DMEM_CTRL_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_loads   <= '0;
      stat_stores  <= '0;
      stat_rejects <= '0;
    end else begin
      if (load_accept && (stat_loads != '1)) begin
        stat_loads <= stat_loads + 32'd1;
      end
      if (store_done && (stat_stores != '1)) begin
        stat_stores <= stat_stores + 32'd1;
      end
      if (src_valid && !accept && (stat_rejects != '1)) begin
        stat_rejects <= stat_rejects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scenarios followed by constrained-random traffic,
// every cycle compared against a queue-based reference model of the port.
module tb_dmem_ctrl;

  localparam int MAX_OUT = 4;
  localparam int TAG_W   = 4;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_load = 1'b0;
  logic [31:0] Dmem_addr = '0;
  logic        start_store = 1'b0;
  logic [31:0] store_addr = '0;
  logic [63:0] store_data = '0;
  logic [1:0]  store_size = '0;
  logic        dm_stalled;
  logic        store_done;
  logic        Dmem_data_ready;
  logic [31:0] Dmem_base_addr;
  logic [63:0] Dmem_load_data;
`ifdef DMEM_CTRL_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_rejects;
`endif

  dmem_ctrl_if #(.TAG_W(TAG_W)) mem_bus ();

  dmem_ctrl #(.MAX_OUT(MAX_OUT), .TAG_W(TAG_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_load      (start_load),
    .Dmem_addr       (Dmem_addr),
    .start_store     (start_store),
    .store_addr      (store_addr),
    .store_data      (store_data),
    .store_size      (store_size),
    .mem             (mem_bus.master),
    .dm_stalled      (dm_stalled),
    .store_done      (store_done),
    .Dmem_data_ready (Dmem_data_ready),
    .Dmem_base_addr  (Dmem_base_addr),
    .Dmem_load_data  (Dmem_load_data)
`ifdef DMEM_CTRL_STATS_EN
    ,
    .stat_loads      (stat_loads),
    .stat_stores     (stat_stores),
    .stat_rejects    (stat_rejects)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding loads as a queue, one pending retry request,
  // and the broadcast expected after the next clock edge.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      addr;
  } ent_t;

  ent_t        out_q[$];
  bit          m_retry;
  bit          m_rb_store;
  logic [31:0] m_rb_addr;
  logic [63:0] m_rb_data;
  logic [1:0]  m_rb_size;
  bit          e_ready;
  logic [31:0] e_base;
  logic [63:0] e_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit tag_busy(input logic [TAG_W-1:0] t);
    foreach (out_q[i]) if (out_q[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stalled();
    return m_retry || (out_q.size() == MAX_OUT);
  endfunction

  task automatic model_clear();
    out_q.delete();
    m_retry = 1'b0;
    e_ready = 1'b0;
    e_base  = '0;
    e_data  = '0;
  endtask

  // One cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input bit sl, input logic [31:0] la,
                      input bit ss, input logic [31:0] sa, input logic [63:0] sd,
                      input logic [1:0] sz, input bit gnt,
                      input logic [TAG_W-1:0] ttag, input logic [TAG_W-1:0] dtag,
                      input logic [63:0] ddata);
    bit          have_src, s_store, drive, acc, found;
    logic [31:0] s_addr;
    logic [63:0] s_data;
    logic [1:0]  s_size;
    int          hit;

    check_val("stalled", 64'(dm_stalled), 64'(model_stalled()));
    check_val("ready", 64'(Dmem_data_ready), 64'(e_ready));
    if (e_ready) begin
      check_val("base", 64'(Dmem_base_addr), 64'(e_base));
      check_val("ldata", Dmem_load_data, e_data);
    end

    start_load  = sl;
    Dmem_addr   = la;
    start_store = ss;
    store_addr  = sa;
    store_data  = sd;
    store_size  = sz;
    mem_bus.mem_gnt                  = gnt;
    mem_bus.mem2proc_transaction_tag = ttag;
    mem_bus.mem2proc_data_tag        = dtag;
    mem_bus.mem2proc_data            = ddata;
    #1;

    have_src = m_retry || sl || ss;
    if (m_retry) begin
      s_store = m_rb_store; s_addr = m_rb_addr; s_data = m_rb_data; s_size = m_rb_size;
    end else if (ss) begin
      s_store = 1'b1; s_addr = sa; s_data = sd; s_size = sz;
    end else begin
      s_store = 1'b0; s_addr = la & 32'hFFFF_FFF8; s_data = '0; s_size = SZ_DOUBLE;
    end
    drive = have_src && gnt;
    acc   = drive && (ttag != 0);

    check_val("cmd", 64'(mem_bus.proc2mem_command),
              64'(drive ? (s_store ? MEM_STORE : MEM_LOAD) : MEM_NONE));
    check_val("addr", 64'(mem_bus.proc2mem_addr), 64'(drive ? s_addr : 32'd0));
    check_val("bdata", mem_bus.proc2mem_data, (drive && s_store) ? s_data : 64'd0);
    check_val("size", 64'(mem_bus.proc2mem_size), 64'(drive ? s_size : 2'd0));
    check_val("store_done", 64'(store_done), 64'(acc && s_store));

    // Responses match only loads outstanding before this edge.
    found = 1'b0;
    hit = 0;
    if (dtag != 0) begin
      foreach (out_q[i]) if (!found && out_q[i].tag == dtag) begin found = 1'b1; hit = i; end
    end
    e_ready = found;
    if (found) begin
      e_base = out_q[hit].addr;
      e_data = ddata;
      out_q.delete(hit);
    end
    if (acc && !s_store) out_q.push_back('{tag: ttag, addr: s_addr});
    if (acc) begin
      m_retry = 1'b0;
    end else if (have_src && !m_retry) begin
      m_retry = 1'b1; m_rb_store = s_store; m_rb_addr = s_addr;
      m_rb_data = s_data; m_rb_size = s_size;
    end

    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit gnt, input logic [TAG_W-1:0] ttag);
    repeat (n) step(0, '0, 0, '0, '0, '0, gnt, ttag, '0, '0);
  endtask

  task automatic load(input logic [31:0] a, input bit gnt, input logic [TAG_W-1:0] ttag);
    step(1, a, 0, '0, '0, '0, gnt, ttag, '0, '0);
  endtask

  task automatic resp(input logic [TAG_W-1:0] dtag, input logic [63:0] d);
    step(0, '0, 0, '0, '0, '0, 0, '0, dtag, d);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start_load = 1'b0;
    start_store = 1'b0;
    mem_bus.mem_gnt = 1'b0;
    mem_bus.mem2proc_transaction_tag = '0;
    mem_bus.mem2proc_data_tag = '0;
    mem_bus.mem2proc_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    #1;
    check_val("rst_stalled", 64'(dm_stalled), 64'd0);
    check_val("rst_ready", 64'(Dmem_data_ready), 64'd0);
    check_val("rst_base", 64'(Dmem_base_addr), 64'd0);
    check_val("rst_ldata", Dmem_load_data, 64'd0);
    check_val("rst_cmd", 64'(mem_bus.proc2mem_command), 64'(MEM_NONE));
    check_val("rst_store_done", 64'(store_done), 64'd0);
  endtask

  initial begin
    bit               sl, ss, gnt;
    logic [31:0]      la, sa;
    logic [63:0]      sd, dd;
    logic [1:0]       sz;
    logic [TAG_W-1:0] tt, dt;
    int               r;

    apply_reset();

    // Idle after reset
    idle(3, 1'b1, 4'd1);

    // Basic load and return
    load(32'h0000_1004, 1'b1, 4'd3);
    idle(1, 1'b0, '0);
    resp(4'd3, 64'hDEAD_BEEF_CAFE_F00D);
    idle(2, 1'b0, '0);

    // Rejected load goes through the retry buffer
    load(32'h0000_2000, 1'b1, 4'd0);
    idle(1, 1'b1, 4'd5);
    idle(1, 1'b0, '0);
    resp(4'd5, 64'h1111_2222_3333_4444);
    idle(1, 1'b0, '0);

    // Fill the table, stall, then free one slot
    for (int i = 1; i <= MAX_OUT; i++) load(32'h0000_0100 * i, 1'b1, TAG_W'(i));
    idle(1, 1'b1, 4'd6);
    resp(4'd2, 64'hAAAA_0000_0000_0002);
    idle(1, 1'b0, '0);
    resp(4'd1, 64'hAAAA_0000_0000_0001);
    resp(4'd3, 64'hAAAA_0000_0000_0003);
    resp(4'd4, 64'hAAAA_0000_0000_0004);
    idle(1, 1'b0, '0);

    // Store waiting two cycles for grant
    step(0, '0, 1, 32'h0000_3008, 64'h0123_4567_89AB_CDEF, SZ_WORD, 0, '0, '0, '0);
    idle(1, 1'b0, '0);
    idle(1, 1'b1, 4'd7);
    idle(1, 1'b0, '0);

    // Unmatched response tag, then the real one
    load(32'h0000_5010, 1'b1, 4'd8);
    resp(4'd9, 64'h9999_9999_9999_9999);
    resp(4'd8, 64'h8888_8888_8888_8888);
    idle(1, 1'b0, '0);

    // Reset with a load outstanding: the late response is ignored
    load(32'h0000_4000, 1'b1, 4'd6);
    apply_reset();
    resp(4'd6, 64'h6666_6666_6666_6666);
    idle(2, 1'b0, '0);

    // Constrained-random traffic
    for (int c = 0; c < 2000; c++) begin
      r  = int'($urandom_range(0, 3));
      sl = !model_stalled() && (r == 1);
      ss = !model_stalled() && (r == 2);
      la = $urandom;
      sa = $urandom;
      sd = {$urandom, $urandom};
      sz = 2'($urandom_range(0, 3));
      gnt = ($urandom_range(0, 3) != 0);
      tt = '0;
      if ($urandom_range(0, 3) != 0) begin
        do tt = TAG_W'($urandom_range(1, (1 << TAG_W) - 1)); while (tag_busy(tt));
      end
      dt = '0;
      r = int'($urandom_range(0, 3));
      if ((r == 1 || r == 2) && out_q.size() > 0) begin
        dt = out_q[$urandom_range(0, out_q.size() - 1)].tag;
      end else if (r == 3) begin
        do dt = TAG_W'($urandom_range(1, (1 << TAG_W) - 1)); while (tag_busy(dt));
      end
      dd = {$urandom, $urandom};
      step(sl, la, ss, sa, sd, sz, gnt, tt, dt, dd);
    end
    idle(2, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
